// File: rtl/cbc_chain_pkg.sv
// Shared constants for the CBC chaining stage: block width default and FSM state encodings.
package cbc_chain_pkg;

    localparam int CBC_DATA_W = 128;

    localparam logic [1:0] CBC_IDLE = 2'h0;
    localparam logic [1:0] CBC_REQ  = 2'h1;
    localparam logic [1:0] CBC_WAIT = 2'h2;
    localparam logic [1:0] CBC_OUT  = 2'h3;

endpackage

// File: rtl/cbc_chain.sv
// CBC chaining stage wrapped around an external 128-bit AES core; one block in flight.
module cbc_chain
    import cbc_chain_pkg::*;
#(
    parameter int DATA_W = CBC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iv_load,
    input  logic [DATA_W-1:0] iv,
    input  logic              decrypt,
    input  logic              in_block_valid,
    output logic              in_block_ready,
    input  logic [DATA_W-1:0] in_block,
    output logic              core_req_valid,
    input  logic              core_req_ready,
    output logic [DATA_W-1:0] core_req_block,
    input  logic              core_resp_valid,
    input  logic [DATA_W-1:0] core_resp_block,
    output logic              out_block_valid,
    input  logic              out_block_ready,
    output logic [DATA_W-1:0] out_block,
    output logic [1:0]        state,
    output logic              empty
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] chain_q, chain_d;
    logic [DATA_W-1:0] cur_q,   cur_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              mode_q,  mode_d;

    assign core_req_block  = cur_q;
    assign out_block       = out_q;
    assign state           = state_q;
    assign empty           = (state_q == CBC_IDLE);
    assign core_req_valid  = (state_q == CBC_REQ);
    assign out_block_valid = (state_q == CBC_OUT);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d        = state_q;
        chain_d        = chain_q;
        cur_d          = cur_q;
        out_d          = out_q;
        mode_d         = mode_q;
        in_block_ready = 1'b0;

        case (state_q)
            CBC_IDLE: begin
                in_block_ready = !iv_load;
                if (iv_load) begin
                    chain_d = iv;
                    mode_d  = decrypt;
                end else if (in_block_valid) begin
                    cur_d   = mode_q ? in_block : (in_block ^ chain_q);
                    state_d = CBC_REQ;
                end
            end
            CBC_REQ: begin
                if (core_req_ready) state_d = CBC_WAIT;
            end
            CBC_WAIT: begin
                if (core_resp_valid) begin
                    if (mode_q) begin
                        // chain_q here is still the previous ciphertext; it is replaced on the same edge.
                        out_d   = core_resp_block ^ chain_q;
                        chain_d = cur_q;
                    end else begin
                        out_d   = core_resp_block;
                        chain_d = core_resp_block;
                    end
                    state_d = CBC_OUT;
                end
            end
            CBC_OUT: begin
                in_block_ready = out_block_ready;
                if (out_block_ready) begin
                    if (in_block_valid) begin
                        cur_d   = mode_q ? in_block : (in_block ^ chain_q);
                        state_d = CBC_REQ;
                    end else begin
                        state_d = CBC_IDLE;
                    end
                end
            end
            default: state_d = CBC_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CBC_IDLE;
            chain_q <= '0;
            cur_q   <= '0;
            out_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cur_q   <= cur_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_cbc_chain.sv
// Directed bench for cbc_chain using NIST SP800-38A CBC-AES128 vectors with a hand-driven core stub.
module tb_cbc_chain;

    localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] X1 = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] X2 = 128'hd86421fb9f1a1eda505ee1375746972c;
    localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv_load;
    logic [127:0] iv;
    logic         decrypt;
    logic         in_block_valid;
    logic         in_block_ready;
    logic [127:0] in_block;
    logic         core_req_valid;
    logic         core_req_ready;
    logic [127:0] core_req_block;
    logic         core_resp_valid;
    logic [127:0] core_resp_block;
    logic         out_block_valid;
    logic         out_block_ready;
    logic [127:0] out_block;
    logic [1:0]   state;
    logic         empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cbc_chain #(.DATA_W(128)) dut (
        .clk             (clk),
        .rst             (rst),
        .iv_load         (iv_load),
        .iv              (iv),
        .decrypt         (decrypt),
        .in_block_valid  (in_block_valid),
        .in_block_ready  (in_block_ready),
        .in_block        (in_block),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req_block  (core_req_block),
        .core_resp_valid (core_resp_valid),
        .core_resp_block (core_resp_block),
        .out_block_valid (out_block_valid),
        .out_block_ready (out_block_ready),
        .out_block       (out_block),
        .state           (state),
        .empty           (empty)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so inputs change away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iv_load = 1'b0; iv = '0; decrypt = 1'b0;
        in_block_valid = 1'b0; in_block = '0; core_req_ready = 1'b0;
        core_resp_valid = 1'b0; core_resp_block = '0; out_block_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_state", 128'(state), 128'(0));
        check("reset_empty", 128'(empty), 128'(1));
        check("reset_req_valid", 128'(core_req_valid), 128'(0));
        check("reset_out_valid", 128'(out_block_valid), 128'(0));
        check("reset_in_ready", 128'(in_block_ready), 128'(1));

        // iv_load and block together: IV wins, block waits
        iv_load = 1'b1; iv = IV; decrypt = 1'b0; in_block_valid = 1'b1; in_block = P1;
        #1;
        check("ivload_blocks_ready", 128'(in_block_ready), 128'(0));
        tick();
        iv_load = 1'b0;
        #1;
        check("ivload_stays_idle", 128'(state), 128'(0));
        check("ivload_ready_after", 128'(in_block_ready), 128'(1));
        tick();
        in_block_valid = 1'b0; in_block = JUNK;
        #1;
        check("enc1_state_req", 128'(state), 128'(1));
        check("enc1_req_block", core_req_block, X1);

        // core request backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("req_bp_valid", 128'(core_req_valid), 128'(1));
            check("req_bp_block", core_req_block, X1);
        end

        // handshake with a stray response in REQ, which must be ignored
        core_req_ready = 1'b1; core_resp_valid = 1'b1; core_resp_block = JUNK;
        tick();
        core_req_ready = 1'b0; core_resp_valid = 1'b0;
        #1;
        check("enc1_state_wait", 128'(state), 128'(2));
        check("enc1_wait_no_out", 128'(out_block_valid), 128'(0));
        tick();
        check("enc1_still_wait", 128'(state), 128'(2));
        core_resp_valid = 1'b1; core_resp_block = C1;
        tick();
        core_resp_valid = 1'b0; core_resp_block = JUNK;
        in_block_valid = 1'b1; in_block = P2;
        #1;
        check("enc1_out_valid", 128'(out_block_valid), 128'(1));
        check("enc1_out_block", out_block, C1);

        // output backpressure for 4 cycles with a pending input
        for (int i = 0; i < 4; i++) begin
            check("out_bp_in_ready", 128'(in_block_ready), 128'(0));
            tick();
            check("out_bp_block", out_block, C1);
            check("out_bp_state", 128'(state), 128'(3));
        end

        // out handshake with simultaneous new block: straight to REQ
        out_block_ready = 1'b1;
        #1;
        check("pass_in_ready", 128'(in_block_ready), 128'(1));
        tick();
        out_block_ready = 1'b0; in_block_valid = 1'b0;
        #1;
        check("enc2_state_req", 128'(state), 128'(1));
        check("enc2_req_block", core_req_block, X2);
        core_req_ready = 1'b1;
        tick();
        core_req_ready = 1'b0; core_resp_valid = 1'b1; core_resp_block = C2;
        tick();
        core_resp_valid = 1'b0;
        #1;
        check("enc2_out_block", out_block, C2);
        out_block_ready = 1'b1;
        tick();
        out_block_ready = 1'b0;
        #1;
        check("enc2_back_idle", 128'(state), 128'(0));
        check("enc2_empty", 128'(empty), 128'(1));

        // decrypt: two chained blocks
        iv_load = 1'b1; iv = IV; decrypt = 1'b1;
        tick();
        iv_load = 1'b0; decrypt = 1'b0; in_block_valid = 1'b1; in_block = C1;
        tick();
        in_block_valid = 1'b0;
        #1;
        check("dec1_req_block", core_req_block, C1);
        core_req_ready = 1'b1;
        tick();
        core_req_ready = 1'b0; core_resp_valid = 1'b1; core_resp_block = X1;
        tick();
        core_resp_valid = 1'b0;
        #1;
        check("dec1_out_block", out_block, P1);
        out_block_ready = 1'b1; in_block_valid = 1'b1; in_block = C2;
        tick();
        out_block_ready = 1'b0; in_block_valid = 1'b0;
        #1;
        check("dec2_state_req", 128'(state), 128'(1));
        check("dec2_req_block", core_req_block, C2);
        core_req_ready = 1'b1;
        tick();
        core_req_ready = 1'b0; core_resp_valid = 1'b1; core_resp_block = X2;
        tick();
        core_resp_valid = 1'b0;
        #1;
        check("dec2_out_block", out_block, P2);
        out_block_ready = 1'b1;
        tick();
        out_block_ready = 1'b0;

        // reset while waiting on the core
        in_block_valid = 1'b1; in_block = JUNK;
        tick();
        in_block_valid = 1'b0; core_req_ready = 1'b1;
        tick();
        core_req_ready = 1'b0;
        #1;
        check("rst_pre_wait", 128'(state), 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_state", 128'(state), 128'(0));
        check("rst_mid_empty", 128'(empty), 128'(1));
        check("rst_mid_req_valid", 128'(core_req_valid), 128'(0));
        check("rst_mid_out_valid", 128'(out_block_valid), 128'(0));
        core_resp_valid = 1'b1; core_resp_block = C1;
        tick();
        core_resp_valid = 1'b0;
        #1;
        check("late_resp_state", 128'(state), 128'(0));
        check("late_resp_out_valid", 128'(out_block_valid), 128'(0));

        // cleared chain and encrypt mode: request equals the plaintext
        in_block_valid = 1'b1; in_block = P1;
        tick();
        in_block_valid = 1'b0;
        #1;
        check("rst_chain_zero", core_req_block, P1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cbc_chain.md
Name: cbc_chain

Overview:
- Cipher-block-chaining stage between the 64-to-128 BE block builder (upstream) and the 128-to-64 BE block splitter (downstream).
- Applies CBC chaining around an external 128-bit AES core:
  - encrypt: XOR plaintext with the chain value before the core.
  - decrypt: XOR the core output with the previous ciphertext.
- One block in flight. Valid/ready on both block sides; request/response to the core.

Parameters:
DATA_W, 128, block width; only 128 is supported; it exists for port sizing.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iv_load  in  1  load IV and mode; honoured only in IDLE
iv  in  DATA_W  initial chain value
decrypt  in  1  mode captured with iv_load (0 = encrypt, 1 = decrypt)
in_block_valid  in  1  upstream block valid
in_block_ready  out  1  stage accepts upstream block
in_block  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt)
core_req_valid  out  1  request to AES core
core_req_ready  in  1  core accepts request
core_req_block  out  DATA_W  core input
core_resp_valid  in  1  single-cycle core result strobe
core_resp_block  in  DATA_W  core result
out_block_valid  out  1  result block valid to splitter
out_block_ready  in  1  splitter accepts
out_block  out  DATA_W  ciphertext (encrypt) or plaintext (decrypt)
state  out  2  current FSM state (debug)
empty  out  1  high in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE; chain_reg, cur_reg, out_reg and mode_reg all cleared to 0.
  - All valid outputs are 0.
  - Reset mid-operation abandons the in-flight block. Any later core_resp_valid is ignored.
- Registers:
  - chain_reg: chain value.
  - cur_reg: core input (encrypt) or captured ciphertext (decrypt).
  - out_reg: output block.
  - mode_reg: captured mode.
- Outputs:
  - core_req_block = cur_reg.
  - out_block = out_reg.
- IDLE (0):
  - empty=1.
  - in_block_ready = !iv_load.
  - If iv_load: chain_reg<=iv, mode_reg<=decrypt. iv_load has priority over a simultaneous block.
  - Else, on in_block_valid:
    - encrypt: cur_reg <= in_block ^ chain_reg.
    - decrypt: cur_reg <= in_block.
    - Next state REQ.
- REQ (1):
  - core_req_valid=1, held with a stable block until core_req_ready.
  - On handshake, next state WAIT.
- WAIT (2):
  - Waits for core_resp_valid.
  - On the strobe, encrypt: out_reg <= core_resp_block; chain_reg <= core_resp_block.
  - On the strobe, decrypt: out_reg <= core_resp_block ^ chain_reg; chain_reg <= cur_reg. Both updates happen in the same edge, so the old chain value is used for the XOR.
  - Next state OUT.
  - core_resp_valid in any other state is ignored.
- OUT (3):
  - out_block_valid=1; out_reg holds until accepted.
  - in_block_ready = out_block_valid & out_block_ready (pass-through acceptance).
  - On output handshake with a simultaneous in_block_valid: capture per the IDLE rules, using the already-updated chain_reg. Next state REQ.
  - On output handshake without a new block: next state IDLE.
  - iv_load is ignored outside IDLE.
- Latency and throughput:
  - Input to core request: 1 cycle.
  - Core response to out_block_valid: 1 cycle.
  - Best case is 1 block per (core latency + 3) cycles.
- Chaining continuity: chain_reg persists across blocks until the next iv_load or rst. A message boundary is marked only by iv_load.
- Width rules: all XORs are full DATA_W, bitwise, with no byte swapping. The builder and splitter already handle endianness.

Decomposition:
- Shared package: state encodings CBC_IDLE=2'h0, CBC_REQ=2'h1, CBC_WAIT=2'h2, CBC_OUT=2'h3; DATA_W default.
- No sub-module; the single FSM plus datapath fits in one module.

Test Plan:
- Encrypt, NIST SP800-38A F.2.1. Stimulus: iv_load with IV=000102030405060708090a0b0c0d0e0f, decrypt=0; then in_block=6bc1bee22e409f96e93d7e117393172a. Required: core_req_block=6bc0bce12a459991e134741a7f9e1925. Stub core returns 7649abac8119b246cee98e9b12e9197d, so out_block must equal that value.
- Encrypt chaining. Second block ae2d8a571e03ac9c9eb76fac45af8e51 -> core_req_block = ae2d8a571e03ac9c9eb76fac45af8e51 ^ 7649abac8119b246cee98e9b12e9197d = d86421fb9f1a1eda505ee1375746972c.
- Decrypt. Stimulus: iv_load IV=0001..0f, decrypt=1; in_block=7649abac8119b246cee98e9b12e9197d; stub returns 6bc0bce12a459991e134741a7f9e1925. Required: core_req_block=7649abac..., out_block=6bc1bee22e409f96e93d7e117393172a. A second input must then see chain_reg=7649abac8119b246cee98e9b12e9197d.
- Backpressure. Hold core_req_ready=0 for 5 cycles: core_req_valid and block stay stable. Hold out_block_ready=0 for 4 cycles: out_block stable, in_block_ready=0.
- Simultaneous events:
  - iv_load and in_block_valid together in IDLE: in_block_ready=0, IV loaded, block taken the next cycle.
  - Out handshake together with a new input in OUT: next state REQ, no IDLE cycle.
  - Stray core_resp_valid in REQ: ignored.
- Reset mid-operation: assert rst in WAIT. Required: state=0, empty=1, chain_reg=0, all valids 0; a following core_resp_valid produces no output.
